// File: rtl/ysyx_24080006_hazard_ctrl.sv
// ysyx_24080006_hazard_ctrl
//
// In-order issue and flush controller. Tracks pending register writes in a
// per-register scoreboard and counts issued-but-not-retired instructions.
// Issue from ID to EX is blocked on RAW/WAW hazards, when the in-flight
// counter is full, or while a redirect or fence.i is being handled. The block
// also sequences EX-stage redirects and the fence.i procedure:
// drain the pipeline, invalidate the icache, then refetch.
//
// Ports:
//   clock, reset           core clock, asynchronous active-high reset
//   id_*                   decoded instruction in ID and its register usage
//   id_issue_ready         issue permitted (combinational)
//   wb_*                   retirement of one instruction and its rd write
//   redirect_req           EX-stage control-flow redirect
//   fencei_req             fence.i waiting in ID
//   lsu_idle               no outstanding LSU/AXI transaction
//   icache_flush_done      icache invalidate complete
//   pipe_flush             kill IF/ID contents and refetch
//   icache_flush_req       level request to invalidate the icache
//   fencei_done            one-cycle pulse when fence.i completes
//   inflight               issued-but-not-retired count
//
// Build option:
//   YSYX_24080006_WB_BYPASS_EN  when defined, a scoreboard bit being cleared
//   by this cycle's writeback is treated as already clear, and a full
//   in-flight counter with a concurrent writeback is not treated as full.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue
// DRAIN    | fence.i seen, waiting for in-flight work and LSU to go idle
// ICFLUSH  | icache invalidate requested, waiting for completion
// REDIRECT | one-cycle pipe flush; fencei_done when ending a fence.i

module ysyx_24080006_hazard_ctrl #(
    parameter int REG_WIDTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_WIDTH-1:0] id_rs1_addr,
    input  logic                 id_rs1_used,
    input  logic [REG_WIDTH-1:0] id_rs2_addr,
    input  logic                 id_rs2_used,
    input  logic [REG_WIDTH-1:0] id_rd_addr,
    input  logic                 id_rd_we,
    output logic                 id_issue_ready,
    input  logic                 wb_valid,
    input  logic                 wb_we,
    input  logic [REG_WIDTH-1:0] wb_rd_addr,
    input  logic                 redirect_req,
    input  logic                 fencei_req,
    input  logic                 lsu_idle,
    input  logic                 icache_flush_done,
    output logic                 pipe_flush,
    output logic                 icache_flush_req,
    output logic                 fencei_done,
    output logic [CNT_W-1:0]     inflight
);

    localparam int               NREG    = 2 ** REG_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_ICFLUSH,
        S_REDIRECT
    } state_e;

    state_e            state_q, state_d;
    logic              fence_q, fence_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    logic [NREG-1:0]   wb_clr;
    logic [NREG-1:0]   iss_set;
    logic [NREG-1:0]   pend_eff;
    logic              cnt_full;
    logic              hazard;
    logic              issue;

    // x0 is never marked pending, so bit 0 of the scoreboard stays 0 and
    // x0 operands can never produce a hazard.
    always_comb begin
        wb_clr = '0;
        if (wb_valid && wb_we && (wb_rd_addr != '0)) begin
            wb_clr[wb_rd_addr] = 1'b1;
        end
    end

    always_comb begin
        iss_set = '0;
        if (issue && id_rd_we && (id_rd_addr != '0)) begin
            iss_set[id_rd_addr] = 1'b1;
        end
    end

`ifdef YSYX_24080006_WB_BYPASS_EN
    assign pend_eff = pend_q & ~wb_clr;
    assign cnt_full = (inflight_q == CNT_MAX) && !wb_valid;
`else
    assign pend_eff = pend_q;
    assign cnt_full = (inflight_q == CNT_MAX);
`endif

    assign hazard = (id_rs1_used && pend_eff[id_rs1_addr]) ||
                    (id_rs2_used && pend_eff[id_rs2_addr]) ||
                    (id_rd_we    && pend_eff[id_rd_addr]);

    assign id_issue_ready = (state_q == S_RUN) && !hazard && !cnt_full &&
                            !redirect_req && !fencei_req;

    assign issue = id_valid && id_issue_ready;

    // Set wins over clear when the same rd issues and retires together.
    assign pend_d = (pend_q & ~wb_clr) | iss_set;

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, wb_valid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fence_d = fence_q;
        case (state_q)
            S_RUN: begin
                if (redirect_req)    state_d = S_REDIRECT;
                else if (fencei_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (redirect_req) begin
                    state_d = S_REDIRECT;
                end else if ((inflight_q == '0) && lsu_idle) begin
                    state_d = S_ICFLUSH;
                end
            end
            S_ICFLUSH: begin
                // Pipeline is empty here, so no redirect can be pending.
                if (icache_flush_done) begin
                    state_d = S_REDIRECT;
                    fence_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                state_d = S_RUN;
                fence_d = 1'b0;
            end
            default: begin
                state_d = S_RUN;
                fence_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            fence_q    <= 1'b0;
            pend_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            fence_q    <= fence_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
        end
    end

    assign pipe_flush       = (state_q == S_REDIRECT);
    assign fencei_done      = (state_q == S_REDIRECT) && fence_q;
    assign icache_flush_req = (state_q == S_ICFLUSH);
    assign inflight         = inflight_q;

endmodule

// File: tb/tb_ysyx_24080006_hazard_ctrl.sv
module tb_ysyx_24080006_hazard_ctrl;

`ifdef YSYX_24080006_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs1_addr = '0;
    logic       id_rs1_used = 1'b0;
    logic [3:0] id_rs2_addr = '0;
    logic       id_rs2_used = 1'b0;
    logic [3:0] id_rd_addr = '0;
    logic       id_rd_we = 1'b0;
    logic       id_issue_ready;
    logic       wb_valid = 1'b0;
    logic       wb_we = 1'b0;
    logic [3:0] wb_rd_addr = '0;
    logic       redirect_req = 1'b0;
    logic       fencei_req = 1'b0;
    logic       lsu_idle = 1'b1;
    logic       icache_flush_done = 1'b0;
    logic       pipe_flush;
    logic       icache_flush_req;
    logic       fencei_done;
    logic [2:0] inflight;

    ysyx_24080006_hazard_ctrl #(.REG_WIDTH(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_issue_ready(id_issue_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
        .redirect_req(redirect_req), .fencei_req(fencei_req),
        .lsu_idle(lsu_idle), .icache_flush_done(icache_flush_done),
        .pipe_flush(pipe_flush), .icache_flush_req(icache_flush_req),
        .fencei_done(fencei_done), .inflight(inflight)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       idv;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2;
        logic [3:0] rd;
        logic       we;
        logic       wbv;
        logic       wbwe;
        logic [3:0] wbrd;
        logic       redir;
        logic       fen;
        logic       lsu;
        logic       icd;
        logic       e_rdy;
        logic       e_pf;
        logic       e_icf;
        logic       e_fd;
        logic [2:0] e_inf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(string n, logic idv, logic [3:0] rs1, logic u1,
                                logic [3:0] rs2, logic u2, logic [3:0] rd, logic we,
                                logic wbv, logic wbwe, logic [3:0] wbrd,
                                logic redir, logic fen, logic lsu, logic icd,
                                logic er, logic epf, logic eicf, logic efd,
                                logic [2:0] einf);
        vec_t v;
        v.name = n; v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.we = we; v.wbv = wbv; v.wbwe = wbwe; v.wbrd = wbrd;
        v.redir = redir; v.fen = fen; v.lsu = lsu; v.icd = icd;
        v.e_rdy = er; v.e_pf = epf; v.e_icf = eicf; v.e_fd = efd; v.e_inf = einf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.idv; id_rs1_addr = v.rs1; id_rs1_used = v.u1;
        id_rs2_addr = v.rs2; id_rs2_used = v.u2; id_rd_addr = v.rd; id_rd_we = v.we;
        wb_valid = v.wbv; wb_we = v.wbwe; wb_rd_addr = v.wbrd;
        redirect_req = v.redir; fencei_req = v.fen; lsu_idle = v.lsu;
        icache_flush_done = v.icd;
    endtask

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    task automatic sample();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: expected-queue empty");
            return;
        end
        e = exp_q.pop_front();
        chk(e.name, "ready", int'(id_issue_ready), int'(e.e_rdy));
        chk(e.name, "pipe_flush", int'(pipe_flush), int'(e.e_pf));
        chk(e.name, "icache_flush_req", int'(icache_flush_req), int'(e.e_icf));
        chk(e.name, "fencei_done", int'(fencei_done), int'(e.e_fd));
        chk(e.name, "inflight", int'(inflight), int'(e.e_inf));
    endtask

    task automatic step(input vec_t v);
        @(negedge clock);
        drive(v);
        exp_q.push_back(v);
        #1;
        sample();
    endtask

    //                 name     idv rs1 u1 rs2 u2 rd we wbv wbwe wbrd red fen lsu icd  rdy pf icf fd inf
    initial begin
        tbl.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("iss_rd5", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("raw_stall", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("raw_wb", 0, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, BYP, 0, 0, 0, 1));
        tbl.push_back(mk("raw_go", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("x0_iss", 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("x0_chk", 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("iss_rd7", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("waw_stall", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk("waw_wb", 0, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0, 0, 1, 0, BYP, 0, 0, 0, 3));
        tbl.push_back(mk("waw_go", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("ret_a", 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 1, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk("ret_b", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("ret_c", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk("fill", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'(i)));
        tbl.push_back(mk("full_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk("full_wb", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, BYP, 0, 0, 0, 7));
        for (int i = 6; i >= 1; i--)
            tbl.push_back(mk("drain", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'(i)));
        tbl.push_back(mk("pre_f0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("pre_f1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("f_req", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk("f_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk("f_wb1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk("f_wb2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("f_lsubusy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("f_lsuidle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("f_ic1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("f_ic2_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("f_ic3_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("f_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("f_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rf_both", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rf_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("rf_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("d_iss3", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("d_freq", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("d_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("d_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("d_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("d_pend3", 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // retire without a write so x3 stays pending into the reset test
        tbl.push_back(mk("e_ret", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("e_freq", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("e_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("e_icf", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));

        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // asynchronous reset in the middle of ICFLUSH
        @(negedge clock);
        drive(mk("rst_async", 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        exp_q.push_back(mk("pre_rst", 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        sample();
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(mk("rst_async", 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        sample();
        @(negedge clock);
        reset = 1'b0;
        step(mk("post_rst_sb", 0, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        step(mk("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        step(mk("post_rst_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d expected entries left", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_24080006_hazard_ctrl.md
Name: ysyx_24080006_hazard_ctrl

Overview:
In-order issue and flush controller for the core pipeline. It holds a per-register pending-write scoreboard and an in-flight instruction counter, and gates issue from ID to EX on RAW/WAW hazards. It also sequences control-flow redirects from EXU and the fence.i drain/icache-flush/refetch procedure. It sits beside the ID/EX stages and drives the flush and icache-flush controls for IFU.

Parameters:
REG_WIDTH, 4, register address width; scoreboard has 2**REG_WIDTH entries.
CNT_W, 3, in-flight counter width; max in flight = 2**CNT_W-1.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a decoded instruction
id_rs1_addr  in  REG_WIDTH  source 1 address
id_rs1_used  in  1  instruction reads rs1
id_rs2_addr  in  REG_WIDTH  source 2 address
id_rs2_used  in  1  instruction reads rs2
id_rd_addr  in  REG_WIDTH  destination address
id_rd_we  in  1  instruction writes rd
id_issue_ready  out  1  issue permitted; issue fires on id_valid && id_issue_ready
wb_valid  in  1  one instruction retires (exactly once per issued instruction)
wb_we  in  1  retiring instruction writes rd
wb_rd_addr  in  REG_WIDTH  retiring destination
redirect_req  in  1  EX-stage branch/jump/ecall/mret redirect
fencei_req  in  1  fence.i sitting in ID (not issued)
lsu_idle  in  1  no outstanding LSU/AXI transaction
icache_flush_done  in  1  icache invalidate complete
pipe_flush  out  1  kill IF/ID contents, refetch
icache_flush_req  out  1  level request to invalidate icache
fencei_done  out  1  fence.i retired, one-cycle pulse
inflight  out  CNT_W  issued-but-not-retired count

Behaviour:
- Reset (async): state=RUN, scoreboard all 0, inflight=0, pipe_flush=0, icache_flush_req=0, fencei_done=0.
- Scoreboard: issue with id_rd_we && rd!=0 sets bit rd; wb_valid && wb_we && rd!=0 clears bit rd. x0 is never pending. Same-cycle set and clear of the same rd: set wins.
- inflight: +1 on issue, -1 on wb_valid, unchanged when both occur; never wraps (issue blocked at max).
- hazard = (rs1_used && pend[rs1]) || (rs2_used && pend[rs2]) || (rd_we && pend[rd]); x0 operands never hazard.
- id_issue_ready (combinational) = state==RUN && !hazard && inflight!=max && !redirect_req && !fencei_req.
- Issue is ID->EX only; the redirecting instruction is the youngest issued, so a redirect never kills issued instructions and the scoreboard needs no rollback.
- FSM:
  - RUN: if redirect_req -> REDIRECT. Else if fencei_req -> DRAIN. redirect_req has priority when both are asserted.
  - DRAIN: if redirect_req -> REDIRECT (fence abandoned). Else if inflight==0 && lsu_idle -> ICFLUSH.
  - ICFLUSH: icache_flush_req=1. On icache_flush_done -> REDIRECT with fence flag set. redirect_req is ignored in this state (pipeline is empty).
  - REDIRECT: pipe_flush=1 for exactly one cycle; fencei_done=1 in the same cycle iff the fence flag is set; flag cleared; -> RUN.
- All outputs except id_issue_ready and inflight are registered state decodes.
- Scoreboard and counter updates from wb_valid continue in every state.
- Reset asserted mid-DRAIN/ICFLUSH: immediate return to reset values, no fencei_done.

Optional Feature:
YSYX_24080006_WB_BYPASS_EN:
- Defined: a pending bit being cleared by wb_valid in the current cycle counts as not pending for hazard evaluation. This gives same-cycle issue, and inflight==max with a concurrent wb_valid is not full.
- Undefined: issue waits one cycle after the clearing writeback.

Test Plan:
- RAW: issue rd=5, next ID rs1=5 -> id_issue_ready=0; wb_valid rd=5 at cycle N -> ready=1 at N+1 (bypass: at N).
- x0: issue rd=0 we=1, next rs1=0 rs2=0 -> ready=1 immediately, scoreboard stays 0.
- WAW/full: issue rd=7 then ID rd=7 -> stall until wb; CNT_W=3, 7 issues, no wb -> 8th stalled, inflight=7.
- fence.i: 2 in flight, fencei_req -> DRAIN; both wb + lsu_idle -> icache_flush_req=1; done after 3 cycles -> next cycle pipe_flush=1 and fencei_done=1 for one cycle, then RUN.
- redirect_req and fencei_req in the same cycle -> REDIRECT, pipe_flush one cycle, fencei_done=0.
- redirect_req in DRAIN -> REDIRECT, no icache_flush_req.
- Reset mid-ICFLUSH -> all outputs 0, inflight=0, scoreboard cleared.
